// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes (also used by the ALU decoder), FSM states, shift-width helper.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  // Shift-amount width; clamped to 1 so a 1-bit datapath still has a legal vector.
  function automatic int unsigned shw_of(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mc_alu_core.sv
// Combinational single-cycle ALU ops. Shifts are a barrel shifter only when MC_ALU_FAST_SHIFT_EN
// is defined; otherwise shift ops pass operand a through (the shamt==0 result).
module mc_alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

`ifdef MC_ALU_FAST_SHIFT_EN
  localparam int unsigned SHW = shw_of(WIDTH);
`endif

  always_comb begin
    y = '0;
    case (alu_control)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef MC_ALU_FAST_SHIFT_EN
      ALU_SLL: y = a << b[SHW-1:0];
      ALU_SRL: y = a >> b[SHW-1:0];
`else
      ALU_SLL, ALU_SRL: y = a;
`endif
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle ops via mc_alu_core, iterative 1-bit/cycle shifts.
// Define MC_ALU_FAST_SHIFT_EN to use the core's barrel shifter instead (all ops latency 1).
module mc_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SHW = shw_of(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             left_q, left_d;
  logic [WIDTH-1:0] core_y;
  logic [WIDTH-1:0] acc_step;
  logic             accept;
  logic             is_shift;

  mc_alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .alu_control(alu_control),
    .a          (a),
    .b          (b),
    .y          (core_y)
  );

  assign accept   = start && (state_q != StShift);
  assign acc_step = left_q ? (acc_q << 1) : (acc_q >> 1);

`ifdef MC_ALU_FAST_SHIFT_EN
  assign is_shift = 1'b0;
`else
  logic [SHW-1:0] shamt;
  assign shamt    = b[SHW-1:0];
  // A zero shift amount completes in one cycle with result = a, straight from the core.
  assign is_shift = ((alu_control == ALU_SLL) || (alu_control == ALU_SRL)) && (shamt != '0);
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    result_d = result_q;
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          if (is_shift) begin
`ifndef MC_ALU_FAST_SHIFT_EN
            acc_d   = a;
            cnt_d   = shamt;
            left_d  = (alu_control == ALU_SLL);
            state_d = StShift;
`endif
          end else begin
            result_d = core_y;
            state_d  = StDone;
          end
        end
      end
      StShift: begin
        acc_d = acc_step;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          result_d = acc_step;
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
  assign zero   = (result_q == '0);
  assign done   = (state_q == StDone);
`ifdef MC_ALU_FAST_SHIFT_EN
  assign busy   = 1'b0;
`else
  assign busy   = (state_q == StShift);
`endif

endmodule
